// File: rtl/qpimem_pkg.sv
// Shared types and widths for the QPI PSRAM line-transfer path.
package qpimem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_XFER      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

endpackage

// File: rtl/qpimem_line_buf.sv
// Line buffer: LINE_WORDS x 32 register file with whole-line load,
// one indexed word write port, indexed word read and flattened read-out.
module qpimem_line_buf
  import qpimem_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                                clk,
  input  logic                                load_i,
  input  logic [WORD_W*LINE_WORDS-1:0]        line_i,
  input  logic                                we_i,
  input  logic [$clog2(LINE_WORDS)-1:0]       idx_i,
  input  logic [WORD_W-1:0]                   wdata_i,
  output logic [WORD_W-1:0]                   rdata_o,
  output logic [WORD_W*LINE_WORDS-1:0]        line_o
);

  logic [LINE_WORDS-1:0][WORD_W-1:0] mem_q;

  // Storage: a full-line load wins over a single-word write; no reset needed.
  always_ff @(posedge clk) begin
    if (load_i) begin
      mem_q <= line_i;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];
  assign line_o  = mem_q;

endmodule

// File: rtl/qpimem_line_xfer.sv
// Line-burst engine in front of qpimem_iface: turns whole-line cache
// requests into one do_read/do_write burst, one word per next_byte pulse.
// Optional watchdog abort is compiled in with `define QPI_XFER_TIMEOUT_EN.
module qpimem_line_xfer
  import qpimem_pkg::*;
#(
  parameter int unsigned LINE_WORDS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] req_wline,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WORD_W*LINE_WORDS-1:0] rsp_rline,
  output logic                         rsp_err,
  output logic                         mem_do_read,
  output logic                         mem_do_write,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WORD_W-1:0]            mem_wdata,
  input  logic [WORD_W-1:0]            mem_rdata,
  input  logic                         mem_next_byte,
  input  logic                         mem_is_idle
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(LINE_WORDS - 1);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic                           write_q;
  logic [ADDR_W-1:0]              addr_q;
  logic                           timeout_c;
  logic                           accept_c;
  logic                           word_ack_c;
  logic [WORD_W-1:0]              buf_word;
  logic [WORD_W*LINE_WORDS-1:0]   buf_line;

  assign accept_c   = (state_q == ST_IDLE) && req_valid;
  assign word_ack_c = (state_q == ST_XFER) && mem_next_byte;

  qpimem_line_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk     (clk),
    .load_i  (accept_c),
    .line_i  (req_wline),
    .we_i    (word_ack_c && !write_q),
    .idx_i   (cnt_q[IDX_W-1:0]),
    .wdata_i (mem_rdata),
    .rdata_o (buf_word),
    .line_o  (buf_line)
  );

`ifdef QPI_XFER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q;
  logic            err_q;
  logic            wdog_busy_c;

  assign wdog_busy_c = (state_q == ST_XFER) || (state_q == ST_DRAIN);
  assign timeout_c   = wdog_busy_c && !word_ack_c &&
                       (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts on XFER entry, on every word and after each expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (((state_q != ST_XFER) && (state_d == ST_XFER)) ||
                 word_ack_c || timeout_c) begin
      wdog_q <= '0;
    end else if (wdog_busy_c) begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end

  // Sticky abort flag, reported with the response and dropped when it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timeout_c) begin
      err_q <= 1'b1;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = (state_q == ST_RESP) && err_q;
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_c      = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req_valid) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (mem_is_idle) state_d = ST_XFER;
      ST_XFER: begin
        if (timeout_c || (mem_next_byte && (cnt_q == LAST_CNT))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:     if (mem_is_idle || timeout_c) state_d = ST_RESP;
      ST_RESP:      if (rsp_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Request capture and word counter; address is aligned down to the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (accept_c) begin
      cnt_q   <= '0;
      write_q <= req_write;
      addr_q  <= req_addr & ~ALIGN_MASK;
    end else if (word_ack_c) begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Outputs: strobe drops once the second-to-last word is acknowledged so the
  // iface sees it low on the pulse of the final word.
  always_comb begin
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rline    = '0;
    mem_do_read  = 1'b0;
    mem_do_write = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_XFER: begin
        mem_addr  = addr_q;
        mem_wdata = buf_word;
        if ((cnt_q < LAST_CNT) && !timeout_c) begin
          mem_do_write = write_q;
          mem_do_read  = !write_q;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rline = buf_line;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qpimem_line_xfer.sv
// Scoreboard bench for qpimem_line_xfer (LINE_WORDS=4) with a behavioural
// qpimem_iface model spacing words 8 cycles apart.
module tb_qpimem_line_xfer;

  localparam int unsigned LW = 4;

  typedef struct {
    logic [23:0] addr;
    logic [31:0] wdata;
    bit          is_wr;
    bit          cont;
  } pulse_t;

  typedef struct {
    logic [127:0] line;
    logic         err;
    bit           chk_line;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [23:0]  req_addr = '0;
  logic [127:0] req_wline = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_rline;
  logic         rsp_err;
  logic         mem_do_read;
  logic         mem_do_write;
  logic [23:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;
  logic         mem_next_byte = 1'b0;
  logic         mem_is_idle = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  pulse_t pulse_q[$];
  rsp_t   exp_rsp[$];

  // iface model state
  bit     active = 0;
  bit     m_write = 0;
  int     gap = 0;
  int     tail = 0;
  int     widx = 0;
  int     hold_busy = 0;
  int     stop_after = 0;
  pulse_t cur_p;
  bit     cont;

  // response monitor state
  int   rsp_delay = 0;
  int   rsp_wait = 0;
  int   n_rsp = 0;
  rsp_t cur_r;

  logic [127:0] rd_line;
  logic [127:0] wr_line;

  qpimem_line_xfer #(
    .LINE_WORDS     (LW),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wline     (req_wline),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rline     (rsp_rline),
    .rsp_err       (rsp_err),
    .mem_do_read   (mem_do_read),
    .mem_do_write  (mem_do_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_next_byte (mem_next_byte),
    .mem_is_idle   (mem_is_idle)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // iface model: acts on the falling edge, samples do_* on each pulse cycle
  always @(negedge clk) begin
    mem_next_byte = 1'b0;
    if (rst) begin
      active      = 0;
      tail        = 0;
      widx        = 0;
      mem_is_idle = 1'b1;
    end else if (active) begin
      gap--;
      if (gap == 0) begin
        cont          = m_write ? mem_do_write : mem_do_read;
        mem_next_byte = 1'b1;
        mem_rdata     = 32'h11111111 * (widx + 1);
        if (pulse_q.size() == 0) begin
          chk("pulse_unexpected", 128'(widx), 128'hFFFF);
        end else begin
          cur_p = pulse_q.pop_front();
          chk("pulse_addr", 128'(mem_addr), 128'(cur_p.addr));
          if (cur_p.is_wr) chk("pulse_wdata", 128'(mem_wdata), 128'(cur_p.wdata));
          chk("pulse_strobe", 128'(cont), 128'(cur_p.cont));
        end
        widx++;
        if (stop_after != 0 && widx == stop_after) begin
          gap = 1000000;
        end else if (cont) begin
          gap = 8;
        end else begin
          active = 0;
          tail   = 2;
          chk("pulse_count", 128'(widx), 128'(LW));
        end
      end
    end else if (tail > 0) begin
      tail--;
      if (tail == 0) mem_is_idle = 1'b1;
    end else if (hold_busy > 0) begin
      hold_busy--;
      mem_is_idle = 1'b0;
    end else begin
      mem_is_idle = 1'b1;
      if (mem_do_read || mem_do_write) begin
        active      = 1;
        m_write     = mem_do_write;
        gap         = 8;
        widx        = 0;
        mem_is_idle = 1'b0;
      end
    end
  end

  // response monitor: pops the scoreboard whenever the DUT presents a line
  always @(negedge clk) begin
    if (rsp_ready) begin
      rsp_ready = 1'b0;
    end else if (rsp_valid) begin
      if (rsp_wait < rsp_delay) begin
        rsp_wait++;
      end else begin
        rsp_wait = 0;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
        end else begin
          cur_r = exp_rsp.pop_front();
          if (cur_r.chk_line) chk("rsp_rline", rsp_rline, cur_r.line);
          chk("rsp_err", 128'(rsp_err), 128'(cur_r.err));
        end
        rsp_ready = 1'b1;
        n_rsp++;
      end
    end
  end

  task automatic push_xfer(input bit w, input logic [23:0] a, input logic [127:0] wl,
                           input logic [127:0] rl, input int words, input bit err, input bit cl);
    pulse_t p;
    rsp_t   r;
    for (int i = 0; i < words; i++) begin
      p.addr  = a;
      p.wdata = wl[32*i +: 32];
      p.is_wr = w;
      p.cont  = (i < LW - 1);
      pulse_q.push_back(p);
    end
    r.line     = rl;
    r.err      = err;
    r.chk_line = cl;
    exp_rsp.push_back(r);
  endtask

  task automatic send(input bit w, input logic [23:0] a, input logic [127:0] l);
    int g = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wline = l;
    while (!req_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("send_accept_bound", 128'(g >= 3000), 128'(0));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while ((exp_rsp.size() != 0 || pulse_q.size() != 0 || rsp_valid || rsp_ready ||
            active || !mem_is_idle) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk(name, 128'(exp_rsp.size() + pulse_q.size()), 128'(0));
    @(negedge clk);
  endtask

  task automatic wait_pulse2;
    int g = 0;
    while (!(active && widx == 2) && g < 1000) begin
      @(posedge clk);
      g++;
    end
    chk("pulse2_bound", 128'(g >= 1000), 128'(0));
  endtask

  initial begin
    int n0;
    int g;
    rd_line = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    wr_line = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 128'(req_ready), 128'(1));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_do_read", 128'(mem_do_read), 128'(0));
    chk("reset_do_write", 128'(mem_do_write), 128'(0));
    chk("reset_rsp_err", 128'(rsp_err), 128'(0));
    chk("reset_mem_addr", 128'(mem_addr), 128'(0));

    // read with unaligned address
    push_xfer(0, 24'h000100, '0, rd_line, LW, 0, 1);
    send(0, 24'h000104, '0);
    wait_done("read_done");

    // write line {D,C,B,A}
    push_xfer(1, 24'h000200, wr_line, wr_line, LW, 0, 1);
    send(1, 24'h000200, wr_line);
    wait_done("write_done");

    // second request held while busy; response held 5 extra cycles
    rsp_delay = 5;
    push_xfer(0, 24'h000300, '0, rd_line, LW, 0, 1);
    send(0, 24'h000300, '0);
    push_xfer(1, 24'h000340, wr_line, wr_line, LW, 0, 1);
    n0        = n_rsp;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'h00034C;
    req_wline = wr_line;
    g = 0;
    while (!req_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("bp_ready_after_rsp", 128'(n_rsp), 128'(n0 + 1));
    @(negedge clk);
    req_valid = 1'b0;
    wait_done("bp_second_done");
    rsp_delay = 0;

    // iface busy for 20+ cycles after accept
    hold_busy = 25;
    push_xfer(0, 24'h000380, '0, rd_line, LW, 0, 1);
    send(0, 24'h000384, '0);
    for (int i = 0; i < 20; i++) begin
      chk("hold_no_strobe", 128'(mem_do_read | mem_do_write), 128'(0));
      @(negedge clk);
    end
    wait_done("hold_done");

    // reset in the middle of a read burst
    push_xfer(0, 24'h000400, '0, rd_line, LW, 0, 1);
    send(0, 24'h000400, '0);
    wait_pulse2();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_do_read", 128'(mem_do_read), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    pulse_q.delete();
    exp_rsp.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // recovery read after reset
    push_xfer(0, 24'h0003F0, '0, rd_line, LW, 0, 1);
    send(0, 24'h0003FC, '0);
    wait_done("recover_done");

`ifdef QPI_XFER_TIMEOUT_EN
    // iface stalls after two words; watchdog aborts and reports the error
    stop_after = 2;
    push_xfer(0, 24'h000500, '0, '0, 2, 1, 0);
    send(0, 24'h000500, '0);
    wait_pulse2();
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (mem_do_read && g < 200);
    chk("timeout_strobe_cycle", 128'(g), 128'(32));
    g = 0;
    while ((exp_rsp.size() != 0 || rsp_valid || rsp_ready) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("timeout_rsp", 128'(exp_rsp.size()), 128'(0));
    stop_after = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_bound: simulation time exceeded, got running expected finished");
    $fatal(1);
  end

endmodule
